// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad-facing lines and the decoded key outputs of
//   keypad_scanner.
//   master : the scanner side (drives columns and the key outputs, reads rows)
//   slave  : the keypad/consumer side (drives rows, reads everything else)
//   Signals:
//     rows      [3:0] row returns, active-high, rows[0] = top row
//     columns   [2:0] one-hot column drive, 3'b100 = left column
//     key       [3:0] last accepted key code (0-9, *=10, #=11)
//     key_valid       one-cycle strobe on an accepted press
//     key_held        high from acceptance until the release is debounced
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [2:0] columns;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input rows, output columns, output key, output key_valid, output key_held);
  modport slave  (output rows, input columns, input key, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Active scanner for a 3-column x 4-row telephone keypad. Drives one column
//   at a time for SCAN_DIV clocks, samples the rows at the end of each dwell,
//   classifies each three-column frame as NONE / SINGLE(code) / MULTI, and
//   debounces press and release over DEBOUNCE_FRAMES identical frames.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    keypad_scanner_if.master (rows in; columns, key, key_valid,
//            key_held out)
//   Parameters:
//     SCAN_DIV         clocks per column dwell (>=2, >=3 with KEYPAD_SYNC_EN)
//     DEBOUNCE_FRAMES  matching frames needed to accept a press or release
//   Optional feature macro: KEYPAD_SYNC_EN
//     Defined   : rows pass through a 2-flop synchronizer before sampling.
//     Undefined : rows are sampled directly (must be stable within a dwell).
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  // Key code for a row/column position; column 0 is the left column.
  // The bottom row holds *, 0, # rather than following the 3r+c+1 pattern.
  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    if (r == 2'd3) begin
      case (c)
        2'd0:    code_of = 4'd10;
        2'd1:    code_of = 4'd0;
        default: code_of = 4'd11;
      endcase
    end else begin
      code_of = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
  endfunction

  logic [3:0] rows_smp;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] rows_meta;
  logic [3:0] rows_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= bus.rows;
      rows_sync <= rows_meta;
    end
  end

  assign rows_smp = rows_sync;
`else
  assign rows_smp = bus.rows;
`endif

  logic [DW-1:0] dwell_q;
  logic [2:0]    col_q;
  logic          sample_now;
  logic          frame_end;

  assign sample_now = (dwell_q == DWELL_LAST);
  assign frame_end  = sample_now && (col_q == 3'b001);

  // Column rotation 100 -> 010 -> 001 -> 100 is a right rotate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
      col_q   <= 3'b100;
    end else if (sample_now) begin
      dwell_q <= '0;
      col_q   <= {col_q[0], col_q[2:1]};
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  logic [1:0] col_idx;
  logic [1:0] smp_cnt;
  logic [3:0] smp_code;

  always_comb begin
    case (col_q)
      3'b100:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      default: col_idx = 2'd2;
    endcase
  end

  // Saturating count of set row bits in this sample (0, 1 or "2+").
  always_comb begin
    smp_cnt  = 2'd0;
    smp_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (rows_smp[r]) begin
        if (smp_cnt != 2'd2) smp_cnt = smp_cnt + 2'd1;
        smp_code = code_of(2'(r), col_idx);
      end
    end
  end

  // Running frame totals; the left-column sample starts a new frame, so the
  // accumulator is ignored there instead of being cleared separately.
  logic [1:0] acc_cnt_q;
  logic [3:0] acc_code_q;
  logic [1:0] base_cnt;
  logic [2:0] cnt_sum;
  logic [1:0] tot_cnt;
  logic [3:0] tot_code;

  assign base_cnt = (col_q == 3'b100) ? 2'd0 : acc_cnt_q;
  assign cnt_sum  = {1'b0, base_cnt} + {1'b0, smp_cnt};
  assign tot_cnt  = (cnt_sum > 3'd1) ? 2'd2 : cnt_sum[1:0];
  assign tot_code = (smp_cnt == 2'd1) ? smp_code : acc_code_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
    end else if (sample_now) begin
      acc_cnt_q  <= tot_cnt;
      acc_code_q <= tot_code;
    end
  end

  logic frame_none;
  logic frame_single;
  assign frame_none   = (tot_cnt == 2'd0);
  assign frame_single = (tot_cnt == 2'd1);

  state_t        state_q, state_d;
  logic [CW-1:0] dcount_q, dcount_d;
  logic [CW-1:0] dcount_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          accept;

  assign dcount_inc = dcount_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dcount_q <= '0;
      cand_q   <= 4'd0;
      key_q    <= 4'd0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcount_q <= dcount_d;
      cand_q   <= cand_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  // Debounce FSM; it only moves at frame end. key_valid is registered so it
  // rises in the clock after the deciding frame-end sample.
  always_comb begin
    state_d  = state_q;
    dcount_d = dcount_q;
    cand_d   = cand_q;
    key_d    = key_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    accept   = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d   = tot_code;
            dcount_d = CW'(1);
            if (DEBOUNCE_FRAMES == 1) accept = 1'b1;
            else                      state_d = PRESS;
          end
        end
        PRESS: begin
          if (frame_single && (tot_code == cand_q)) begin
            dcount_d = dcount_inc;
            if (dcount_inc == DB_TARGET) accept = 1'b1;
          end else begin
            state_d  = IDLE;
            dcount_d = '0;
          end
        end
        HELD: begin
          if (frame_none) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d  = IDLE;
              held_d   = 1'b0;
              dcount_d = '0;
            end else begin
              state_d  = RELEASE;
              dcount_d = CW'(1);
            end
          end
        end
        RELEASE: begin
          if (frame_none) begin
            if (dcount_inc == DB_TARGET) begin
              state_d  = IDLE;
              held_d   = 1'b0;
              dcount_d = '0;
            end else begin
              dcount_d = dcount_inc;
            end
          end else begin
            state_d  = HELD;
            dcount_d = '0;
          end
        end
      endcase
      if (accept) begin
        key_d    = cand_d;
        valid_d  = 1'b1;
        held_d   = 1'b1;
        state_d  = HELD;
        dcount_d = '0;
      end
    end
  end

  assign bus.columns   = col_q;
  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives keypad_scanner from a behavioural keypad (a 12-bit mask of pressed
//   keys turned into row returns from the driven column) and checks it
//   against a frame-level reference model of the debounce rules.
module tb_keypad_scanner;
  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_FRAMES = 2;
  localparam int FRAME_CLKS      = 3 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mask = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  keypad_scanner_if kp_bus ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kp_bus)
  );

  always #5 clk = ~clk;

  // Keypad layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #, * = code 10, # = code 11.
  function automatic int key_row(input int k);
    if (k == 0 || k == 10 || k == 11) return 3;
    return (k - 1) / 3;
  endfunction

  function automatic int key_col(input int k);
    if (k == 0)  return 1;
    if (k == 10) return 0;
    if (k == 11) return 2;
    return (k - 1) % 3;
  endfunction

  // Behavioural keypad: a pressed key connects its column to its row.
  always_comb begin
    kp_bus.rows = '0;
    for (int k = 0; k < 12; k++) begin
      if (mask[k] && kp_bus.columns[2 - key_col(k)]) kp_bus.rows[key_row(k)] = 1'b1;
    end
  end

  // Reference model state, advanced once per complete frame.
  int         m_streak;
  int         m_rel;
  int         m_cand;
  bit         m_held;
  logic [3:0] m_key;
  bit         m_accept;

  task automatic modelReset();
    m_streak = 0;
    m_rel    = 0;
    m_cand   = 0;
    m_held   = 0;
    m_key    = 4'd0;
    m_accept = 0;
  endtask

  task automatic modelFrame(input logic [11:0] m);
    int n;
    int code;
    n    = $countones(m);
    code = 0;
    for (int k = 0; k < 12; k++) if (m[k]) code = k;
    m_accept = 0;
    if (!m_held) begin
      if (n == 1 && m_streak > 0 && code == m_cand) m_streak++;
      else if (n == 1 && m_streak == 0) begin
        m_cand   = code;
        m_streak = 1;
      end else m_streak = 0;
      if (m_streak == DEBOUNCE_FRAMES) begin
        m_accept = 1;
        m_key    = 4'(m_cand);
        m_held   = 1;
        m_streak = 0;
        m_rel    = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DEBOUNCE_FRAMES) begin
          m_held = 0;
          m_rel  = 0;
        end
      end else m_rel = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Holds mask m for whole frames; every cycle checks the column drive and
  // that no stray strobe appears, and each frame end checks the key outputs.
  task automatic applyStimulus(input logic [11:0] m, input int frames);
    mask = m;
    for (int f = 0; f < frames; f++) begin
      for (int k = 1; k <= FRAME_CLKS; k++) begin
        @(posedge clk);
        #1;
        checkOutput("columns", 32'(kp_bus.columns), 32'(3'b100 >> ((k / SCAN_DIV) % 3)));
        if (k < FRAME_CLKS) begin
          checkOutput("no_stray_valid", 32'(kp_bus.key_valid), 32'd0);
        end else begin
          modelFrame(m);
          checkOutput("key_valid", 32'(kp_bus.key_valid), 32'(m_accept));
          checkOutput("key", 32'(kp_bus.key), 32'(m_key));
          checkOutput("key_held", 32'(kp_bus.key_held), 32'(m_held));
        end
      end
    end
  endtask

  // Runs pre clocks into a frame, then asserts reset mid-dwell and checks
  // that the outputs clear without waiting for a clock edge.
  task automatic resetDut(input int pre);
    for (int k = 1; k <= pre; k++) begin
      @(posedge clk);
      #1;
      checkOutput("columns_pre_reset", 32'(kp_bus.columns), 32'(3'b100 >> ((k / SCAN_DIV) % 3)));
      checkOutput("no_valid_pre_reset", 32'(kp_bus.key_valid), 32'd0);
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_columns", 32'(kp_bus.columns), 32'(3'b100));
    checkOutput("rst_key", 32'(kp_bus.key), 32'd0);
    checkOutput("rst_key_valid", 32'(kp_bus.key_valid), 32'd0);
    checkOutput("rst_key_held", 32'(kp_bus.key_held), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("por_columns", 32'(kp_bus.columns), 32'(3'b100));
    checkOutput("por_key", 32'(kp_bus.key), 32'd0);
    checkOutput("por_key_valid", 32'(kp_bus.key_valid), 32'd0);
    checkOutput("por_key_held", 32'(kp_bus.key_held), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle rotation, then reset mid-dwell.
    applyStimulus(12'd0, 2);
    resetDut(6);
    applyStimulus(12'd0, 1);

    // Press 4 for 5 frames, release for 3.
    applyStimulus(12'(1 << 4), 5);
    applyStimulus(12'd0, 3);

    // Sequence 8, 2, 1, *, #.
    applyStimulus(12'(1 << 8), 4);
    applyStimulus(12'd0, 4);
    applyStimulus(12'(1 << 2), 4);
    applyStimulus(12'd0, 4);
    applyStimulus(12'(1 << 1), 4);
    applyStimulus(12'd0, 4);
    applyStimulus(12'(1 << 10), 4);
    applyStimulus(12'd0, 4);
    applyStimulus(12'(1 << 11), 4);
    applyStimulus(12'd0, 4);

    // Bounce on 5.
    applyStimulus(12'(1 << 5), 1);
    applyStimulus(12'd0, 1);
    applyStimulus(12'(1 << 5), 3);
    applyStimulus(12'd0, 3);

    // Ghost press of 2+3, then rollover 7 -> 7+9.
    applyStimulus(12'((1 << 2) | (1 << 3)), 3);
    applyStimulus(12'd0, 2);
    applyStimulus(12'(1 << 7), 2);
    applyStimulus(12'((1 << 7) | (1 << 9)), 3);
    applyStimulus(12'd0, 3);

    // Reset one frame into a press of 6, with 6 still held afterwards.
    applyStimulus(12'(1 << 6), 1);
    resetDut(5);
    applyStimulus(12'(1 << 6), 3);
    applyStimulus(12'd0, 3);

    // Randomized presses, releases and multi-key frames.
    for (int s = 0; s < 40; s++) begin
      int          sel;
      int          a;
      int          b;
      logic [11:0] m;
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 11));
      b   = int'($urandom_range(0, 11));
      if (sel < 3)       m = 12'd0;
      else if (sel == 3) m = 12'((1 << a) | (1 << b));
      else               m = 12'(1 << a);
      applyStimulus(m, int'($urandom_range(1, 4)));
    end
    applyStimulus(12'd0, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanner for the 3-column x 4-row telephone keypad of the clock design.
- Drives one column at a time and samples the row lines that the keypad returns.
- Decodes the pressed key into a 4-bit value, debounces press and release, and emits a one-cycle strobe per press.
- It is the reading end of the `keypad` model: that model converts key+columns into rows, and this block converts columns+rows back into a key.

Parameters:
SCAN_DIV, 4, clocks each column is driven before rows are sampled (>=2; >=3 when KEYPAD_SYNC_EN)
DEBOUNCE_FRAMES, 2, consecutive identical full scan frames required to accept a press or a release (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rows  input  4  row returns, active-high; rows[0]=top row (1,2,3) .. rows[3]=bottom row (*,0,#)
columns  output  3  one-hot active-high column drive; 3'b100=left (1,4,7,*), 3'b010=middle (2,5,8,0), 3'b001=right (3,6,9,#)
key  output  4  last accepted key code
key_valid  output  1  one-cycle strobe on an accepted press
key_held  output  1  high from acceptance until the release is debounced

Behaviour:
- Reset (async, immediate): columns=3'b100, key=4'd0, key_valid=0, key_held=0, dwell count=0, FSM=IDLE, debounce count=0, candidate=0.
- Key codes: digits 0-9 map to 4'd0-4'd9; *=4'd10; #=4'd11. Codes 12-15 are never produced.
- Dwell counter runs 0..SCAN_DIV-1. On count==SCAN_DIV-1, rows are sampled for the current column and the column rotates 100->010->001->100.
- A frame is three consecutive column samples, and it ends at the 001 sample.
- Frame classification:
  - NONE: all samples zero.
  - SINGLE(code): exactly one row bit set across the whole frame.
  - MULTI: more than one row bit set in total.
- FSM transitions, evaluated only at frame end:
  - IDLE: SINGLE(c) -> candidate=c, dcount=1. If DEBOUNCE_FRAMES==1, accept immediately; otherwise go to PRESS. NONE or MULTI -> stay in IDLE.
  - PRESS: SINGLE(candidate) -> dcount++, and accept when dcount reaches DEBOUNCE_FRAMES. Any other class -> IDLE, dcount=0.
  - Accept: key<=candidate, key_valid=1 for exactly the next cycle, key_held=1, go to HELD.
  - HELD: NONE -> dcount=1, go to RELEASE (if DEBOUNCE_FRAMES==1, go straight to IDLE with key_held=0). SINGLE or MULTI -> stay in HELD.
  - RELEASE: NONE -> dcount++; on reaching DEBOUNCE_FRAMES, key_held=0 and go to IDLE. SINGLE or MULTI -> back to HELD.
- Latency: key_valid rises in the clock after the frame-end sample of the DEBOUNCE_FRAMES-th matching frame. The minimum is 3*SCAN_DIV*DEBOUNCE_FRAMES clocks from the first frame start.
- key holds its value until the next accept. It is not cleared on release.
- A rollover (second key added while HELD) produces no new strobe. After release is debounced, a fresh press is required.
- The scan never stalls. columns is always exactly one-hot.
- Reset asserted mid-frame or mid-debounce aborts all state to reset values. No strobe is emitted while reset is high or in the cycle of deassertion.

Optional Feature:
- Macro: KEYPAD_SYNC_EN.
- Defined: rows passes through a 2-flop synchronizer reset to 0, and the samples use the synchronized value. SCAN_DIV must be >=3 so the sample reflects the current column. Every strobe arrives 0 extra frames later but with 2 clocks of pipelining in the sample path.
- Undefined: rows is sampled directly. This requires rows to be stable within the dwell (the combinational `keypad` model satisfies this).

Test Plan:
Bench settings: SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame = 12 clocks. A behavioural keypad model drives rows from the pressed key and columns.
- Reset: assert reset mid-dwell -> columns=3'b100, key=0, key_valid=0, key_held=0 immediately. Release reset -> columns rotate every 4 clocks (100,010,001).
- Press 4 (left column, row 1) held for 5 frames -> exactly one key_valid pulse with key=4'd4, 24 clocks after press start aligned to a frame. key_held=1 until 2 empty frames after release.
- Sequence 8, 2, 1, *, #, each held 4 frames with 4 idle frames between -> strobes with key=8, 2, 1, 10, 11 in order and one strobe each.
- Bounce: press 5 for 1 frame, release 1 frame, press 5 for 3 frames -> a single strobe key=5, none after the first frame.
- Ghost/rollover: press 2 and 3 together from IDLE -> no strobe. Hold 7, then add 9 while held -> one strobe key=7 only, key_held stays 1. Release both -> key_held falls after 2 empty frames.
- Reset during PRESS (1 frame into a 6 press) -> no strobe. After reset release with 6 still held -> strobe key=6 after 2 frames.
